spine_link_buffer: RTL and testbench
====================================

// Module: spine_link_buffer
// PURPOSE
//  Elastic link stage between a group router's spineN_out_* port and the peer router's spineN_in_* port.
//  Absorbs bursts in a DEPTH-entry FIFO and derives the 6-bit destination address from the flit header.
//  Presents a registered valid/ready output, so spine links can be retimed and throttled.
//  The router's spine output has no backpressure, so this stage is where overflow is detected and counted.
// PARAMETERS
//  DWIDTH   16  flit width; matches the router DWIDTH
//  DEPTH    8   FIFO entries; power of two, >= 2
//  ADDR_HI  15  MSB of the destination field in the flit
//  ADDR_LO  10  LSB of the destination field (ADDR_HI-ADDR_LO+1 == 6)
// PORTS
//  clk            in   1               single clock domain
//  reset          in   1               synchronous, active-high
//  in_data        in   DWIDTH          from upstream router spineN_out_data
//  in_valid       in   1               from upstream router spineN_out_valid; no ready is returned
//  out_data       out  DWIDTH          to downstream spineN_in_data
//  out_valid      out  1               to downstream spineN_in_valid
//  out_dest_addr  out  6               to downstream spineN_dest_addr; = out_data[ADDR_HI:ADDR_LO]
//  out_ready      in   1               downstream accept; tie to 1'b1 for always-ready routers
//  fifo_full      out  1               count == DEPTH
//  fifo_empty     out  1               count == 0; the output register is excluded
//  level          out  $clog2(DEPTH)+1 FIFO occupancy; the output register is excluded
//  drop_count     out  16              flits lost to overflow; saturates at 16'hFFFF
//  high_water     out  $clog2(DEPTH)+1 maximum level reached since reset
// BEHAVIOUR
//  Reset (sync, active-high)
//   - wr_ptr = rd_ptr = 0; out_valid = 0; out_data = 0; out_dest_addr = 0.
//   - drop_count = 0; high_water = 0; fifo_empty = 1; fifo_full = 0.
//   - Reset asserted mid-burst discards all queued flits and the output register in the same edge.
//  Pointers
//   - $clog2(DEPTH)+1 bits; MSB is the wrap bit. full = MSBs differ and the rest are equal.
//   - Natural binary wrap; no explicit modulo logic.
//  Output stage FSM
//   - States: IDLE (out_valid=0) and HOLD (out_valid=1).
//   - IDLE -> HOLD when the FIFO is not empty, or in_valid while the FIFO is empty (bypass write).
//   - HOLD -> HOLD when out_ready=0: out_data and out_dest_addr stay stable.
//   - HOLD -> HOLD when out_ready=1 and a next flit exists (FIFO or bypass): reload that flit.
//   - HOLD -> IDLE when out_ready=1 and no next flit exists.
//   - Ordering is strict FIFO; a bypass is taken only when the FIFO is empty.
//  Latency
//   - in_valid at edge N -> out_valid at edge N+1 (one cycle, empty path).
//   - Sustained throughput is 1 flit/cycle when out_ready=1.
//  Push rules
//   - Accept when !fifo_full, or when a pop happens in the same cycle (full with push+pop keeps level = DEPTH).
//   - Otherwise the flit is dropped: FIFO unchanged, drop_count += 1 (saturating).
//  Simultaneous push and pop: level unchanged; both pointers advance.
//  out_dest_addr is registered with out_data and is never combinational from in_data.
// CONFIGURATION
//  Macro: SPINE_LINK_STATS_EN
//   - Defined: drop_count and high_water behave as described above.
//   - Undefined: both outputs tie to 0 and their registers are removed.
//   - Drop behaviour itself is identical in both builds.
// STRUCTURE
//  Package spine_pkg
//   - SPINE_DWIDTH=16, DEST_HI=15, DEST_LO=10, DEST_W=6.
//   - typedef logic [15:0] spine_flit_t; typedef logic [5:0] spine_dest_t.
//   - function dest_of(flit) returns the destination field.
//  Sub-module spine_fifo_mem: DEPTH x DWIDTH register array.
//   - One write port; combinational read at rd_ptr.
//   - Pointer, flag, FSM and stats logic stay in spine_link_buffer.
// TESTING
//  1. Single flit 16'hA5C3 at cycle 0, out_ready=1 -> out_valid at cycle 1 only; out_dest_addr=6'h29; level stays 0.
//  2. 8 back-to-back flits with out_ready=0 (DEPTH=8):
//     - first flit sits in the output register; 7 flits go to the FIFO (level=7).
//     - a 9th flit fills the FIFO (full=1); a 10th flit gives drop_count=1.
//     - releasing ready drains all 9 flits in order with no bubbles.
//  3. FIFO full plus in_valid and out_ready=1 in the same cycle -> no drop, level stays 8, pointers wrap correctly over 3 full laps.
//  4. Reset asserted while level=5 and out_valid=1 -> next cycle out_valid=0, level=0, drop_count=0, high_water=0.
//  5. out_ready toggling 1010... with continuous input:
//     - sequence is preserved and out_data is stable while out_valid && !out_ready.
//     - high_water settles to the observed peak.
//  6. Build without SPINE_LINK_STATS_EN, repeat test 2 -> identical data and drops; drop_count=0 and high_water=0 throughout.

Source files
------------

// File: rtl/spine_pkg.sv
// Shared types and field positions for spine link flits.
package spine_pkg;
    localparam int SPINE_DWIDTH = 16;
    localparam int DEST_HI      = 15;
    localparam int DEST_LO      = 10;
    localparam int DEST_W       = 6;

    typedef logic [15:0] spine_flit_t;
    typedef logic [5:0]  spine_dest_t;

    typedef enum logic {ST_IDLE, ST_HOLD} out_state_t;

    function automatic spine_dest_t dest_of(input spine_flit_t flit);
        return flit[DEST_HI:DEST_LO];
    endfunction
endpackage

// File: rtl/spine_fifo_mem.sv
// DEPTH x DWIDTH flit storage: one write port, combinational read.
module spine_fifo_mem #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DWIDTH-1:0] rd_data
);
    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/spine_link_buffer.sv
// Elastic spine link stage: FIFO plus registered output with overflow drop.
// Optional stats (drop_count, high_water) are built only with SPINE_LINK_STATS_EN.
module spine_link_buffer
    import spine_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int DEPTH   = 8,
    parameter int ADDR_HI = 15,
    parameter int ADDR_LO = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        in_data,
    input  logic                     in_valid,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_valid,
    output logic [5:0]               out_dest_addr,
    input  logic                     out_ready,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   high_water
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr, rd_ptr, count;
    logic [DWIDTH-1:0] rd_data, load_data;
    logic              push, pop, bypass, load;
    out_state_t        state, state_next;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level      = count;
    assign out_valid  = (state == ST_HOLD);

    spine_fifo_mem #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    // The output register reloads when idle or when its flit is taken;
    // the FIFO head always has priority so order is preserved.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        bypass     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_HOLD;
                end else if (in_valid) begin
                    bypass     = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (!fifo_empty)   pop        = 1'b1;
                    else if (in_valid) bypass     = 1'b1;
                    else               state_next = ST_IDLE;
                end
            end
        endcase
    end

    assign load      = pop || bypass;
    assign load_data = pop ? rd_data : in_data;
    assign push      = in_valid && !bypass && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            state         <= ST_IDLE;
            out_data      <= '0;
            out_dest_addr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            state  <= state_next;
            if (load) begin
                out_data      <= load_data;
                out_dest_addr <= load_data[ADDR_HI:ADDR_LO];
            end
        end
    end

`ifdef SPINE_LINK_STATS_EN
    logic          drop;
    logic [15:0]   drop_q;
    logic [PW-1:0] hw_q, count_next;

    assign drop       = in_valid && !bypass && !push;
    assign count_next = count + PW'(push) - PW'(pop);

    // Tracks the post-edge level so high_water moves together with level.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
            hw_q   <= '0;
        end else begin
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (count_next > hw_q)          hw_q   <= count_next;
        end
    end

    assign drop_count = drop_q;
    assign high_water = hw_q;
`else
    assign drop_count = '0;
    assign high_water = '0;
`endif
endmodule

// File: tb/tb_spine_link_buffer.sv
// Directed bench for spine_link_buffer (DEPTH=8); stats expectations follow SPINE_LINK_STATS_EN.
module tb_spine_link_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic [5:0]  out_dest_addr;
    logic        out_ready;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  level;
    logic [15:0] drop_count;
    logic [3:0]  high_water;

    int total = 0;
    int bad   = 0;

`ifdef SPINE_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    spine_link_buffer #(.DWIDTH(16), .DEPTH(8), .ADDR_HI(15), .ADDR_LO(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_dest_addr (out_dest_addr),
        .out_ready     (out_ready),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .level         (level),
        .drop_count    (drop_count),
        .high_water    (high_water)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0000", out_data); end
        total++; if (out_dest_addr !== 6'h0) begin bad++; $display("FAIL reset_dest got=%h want=00", out_dest_addr); end
        total++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", fifo_empty, fifo_full); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (drop_count !== 16'd0 || high_water !== 4'd0) begin bad++; $display("FAIL reset_stats got drop=%0d hw=%0d want 0/0", drop_count, high_water); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1; in_data = 16'hA5C3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 16'hA5C3) begin bad++; $display("FAIL single_out got v=%b d=%h want 1/a5c3", out_valid, out_data); end
        total++; if (out_dest_addr !== 6'h29) begin bad++; $display("FAIL single_dest got=%h want=29", out_dest_addr); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL single_level got=%0d want=0", level); end
        tick();
        total++; if (out_valid !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL single_gone got v=%b lvl=%0d want 0/0", out_valid, level); end
    endtask

    task automatic test_burst();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'(16'h1000 + (i << 10) + i); in_valid = 1'b1;
            tick();
            if (i == 7) begin
                total++; if (level !== 4'd7 || fifo_full !== 1'b0) begin bad++; $display("FAIL burst_lvl7 got lvl=%0d full=%b want 7/0", level, fifo_full); end
            end
            if (i == 8) begin
                total++; if (level !== 4'd8 || fifo_full !== 1'b1) begin bad++; $display("FAIL burst_full got lvl=%0d full=%b want 8/1", level, fifo_full); end
            end
        end
        in_valid = 1'b0;
        total++; if (level !== 4'd8) begin bad++; $display("FAIL burst_after_drop got lvl=%0d want=8", level); end
        total++; if (drop_count !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL burst_drop got=%0d want=%0d", drop_count, STATS ? 1 : 0); end
        total++; if (high_water !== (STATS ? 4'd8 : 4'd0)) begin bad++; $display("FAIL burst_hw got=%0d want=%0d", high_water, STATS ? 8 : 0); end
        total++; if (out_valid !== 1'b1 || out_data !== 16'h1000) begin bad++; $display("FAIL burst_head got v=%b d=%h want 1/1000", out_valid, out_data); end
        out_ready = 1'b1;
        for (int k = 1; k < 9; k++) begin
            logic [15:0] exp;
            exp = 16'(16'h1000 + (k << 10) + k);
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== exp) begin bad++; $display("FAIL burst_drain%0d got v=%b d=%h want 1/%h", k, out_valid, out_data, exp); end
            total++; if (out_dest_addr !== exp[15:10]) begin bad++; $display("FAIL burst_dest%0d got=%h want=%h", k, out_dest_addr, exp[15:10]); end
        end
        tick();
        total++; if (out_valid !== 1'b0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL burst_end got v=%b empty=%b want 0/1", out_valid, fifo_empty); end
        total++; if (drop_count !== (STATS ? 16'd1 : 16'd0)) begin bad++; $display("FAIL burst_drop_end got=%0d want=%0d", drop_count, STATS ? 1 : 0); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 9; n++) begin
            in_data = 16'(16'h2000 + n); in_valid = 1'b1;
            tick();
        end
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL wrap_fill got full=%b want 1", fifo_full); end
        out_ready = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            in_data = 16'(16'h2000 + 8 + j); in_valid = 1'b1;
            tick();
            total++; if (level !== 4'd8 || fifo_full !== 1'b1) begin bad++; $display("FAIL wrap_level%0d got lvl=%0d full=%b want 8/1", j, level, fifo_full); end
            total++; if (out_data !== 16'(16'h2000 + j)) begin bad++; $display("FAIL wrap_data%0d got=%h want=%h", j, out_data, 16'(16'h2000 + j)); end
        end
        in_valid = 1'b0;
        for (int j = 25; j <= 32; j++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 16'(16'h2000 + j)) begin bad++; $display("FAIL wrap_drain%0d got v=%b d=%h want 1/%h", j, out_valid, out_data, 16'(16'h2000 + j)); end
        end
        tick();
        total++; if (out_valid !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL wrap_end got v=%b lvl=%0d want 0/0", out_valid, level); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL wrap_nodrop got=%0d want=0", drop_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            in_data = 16'(16'h4000 + n); in_valid = 1'b1;
            tick();
        end
        total++; if (level !== 4'd5 || out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got lvl=%0d v=%b want 5/1", level, out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || level !== 4'd0 || fifo_empty !== 1'b1) begin bad++; $display("FAIL midrst_post got v=%b lvl=%0d empty=%b want 0/0/1", out_valid, level, fifo_empty); end
        total++; if (drop_count !== 16'd0 || high_water !== 4'd0) begin bad++; $display("FAIL midrst_stats got drop=%0d hw=%0d want 0/0", drop_count, high_water); end
        total++; if (out_data !== 16'h0) begin bad++; $display("FAIL midrst_data got=%h want=0000", out_data); end
    endtask

    task automatic test_toggle();
        logic [15:0] exp_q[$];
        logic [15:0] held;
        logic        hold_chk;
        logic [3:0]  peak;
        do_reset();
        hold_chk = 1'b0; peak = '0; held = '0;
        for (int i = 0; i < 16; i++) begin
            if (hold_chk) begin
                total++; if (out_data !== held) begin bad++; $display("FAIL toggle_stable%0d got=%h want=%h", i, out_data, held); end
            end
            if (level > peak) peak = level;
            out_ready = (i % 2 == 0);
            if (i < 12) begin
                in_data = 16'(16'h3000 + (i << 11) + i); in_valid = 1'b1;
                exp_q.push_back(in_data);
            end else in_valid = 1'b0;
            hold_chk = out_valid && !out_ready;
            held     = out_data;
            if (out_valid && out_ready) begin
                total++; if (exp_q.size() == 0 || out_data !== exp_q[0] || out_dest_addr !== out_data[15:10]) begin bad++; $display("FAIL toggle_order%0d got=%h", i, out_data); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            if (level > peak) peak = level;
            if (out_valid) begin
                total++; if (out_data !== exp_q[0]) begin bad++; $display("FAIL toggle_drain got=%h want=%h", out_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            tick();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL toggle_timeout got left=%0d want=0", exp_q.size()); end
        total++; if (peak < 4'd2) begin bad++; $display("FAIL toggle_backlog got peak=%0d want>=2", peak); end
        total++; if (high_water !== (STATS ? peak : 4'd0)) begin bad++; $display("FAIL toggle_hw got=%0d want=%0d", high_water, STATS ? peak : 4'd0); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL toggle_nodrop got=%0d want=0", drop_count); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_burst();
        test_full_wrap();
        test_reset_mid();
        test_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
